arbitro_rr4: RTL and testbench
==============================

# arbitro_rr4

Round-robin controller that shares the team's 4-input, 1-bit multiplexer (`mux4a1`) between four requesters. It registers a one-hot grant and the 2-bit select, and holds a grant while the owner keeps requesting. With the timeout feature compiled in, it also forces release after a bounded hold. It sits in front of `mux4a1`, the single-bit shared path, and drives the mux select so that only the granted source reaches `out`.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles of one grant when timeout is enabled; legal range 1..15.
- `HOLD_W`, default 4: width of the hold counter; must satisfy `2**HOLD_W > MAX_HOLD`.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high reset; sampled only on the rising edge of `clk`.
- `req`  in  4  — request lines; `req[i]` belongs to requester i.
- `d`  in  4  — data bits; `d[0]..d[3]` map to mux inputs a..d.
- `gnt`  out  4  — registered one-hot grant, or all zero.
- `sel`  out  2  — registered mux select; equals the index of the set `gnt` bit while busy.
- `busy`  out  1  — registered; 1 when any grant is active.
- `out`  out  1  — shared output: mux output when `busy`=1, else 0.

## Operation
- State: FSM {IDLE, GRANT}, round-robin pointer `last[1:0]`, hold counter `cnt[HOLD_W-1:0]`.
- Arbitration: scan indices `last+1, last+2, last+3, last+4` modulo 4; the first index with `req` high wins.
- IDLE:
  - If `req` != 0, arbitrate. Set `gnt`, `sel`, and `last` to the winner, set `busy`=1, clear `cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, owner still requesting (`req[sel]`=1), no timeout: hold the grant and increment `cnt`, saturating at all-ones.
- GRANT, release condition (`req[sel]`=0, or timeout expiry):
  - Re-arbitrate over the current `req` in the same edge. Back-to-back handoff, no idle cycle.
  - If a winner exists, load the new `gnt`/`sel`/`last` and clear `cnt`.
  - If none exists, clear `gnt`, set `busy`=0, go to IDLE. `sel` keeps its last value.
- Timeout expiry: `cnt == MAX_HOLD-1` while `req[sel]`=1. If the owner is the only requester, the scan wraps back to it; it is re-granted and `cnt` is cleared.
- Datapath: `out` = `busy` AND `mux4a1(d, sel)`. This path is combinational, with no register.

## Timing
- Reset values: `gnt`=4'b0000, `sel`=2'b00, `busy`=0, `out`=0, `last`=2'b11 (requester 0 has first priority), `cnt`=0, state=IDLE.
- Grant latency: a request sampled high at edge N produces a grant visible after edge N (one cycle).
- Release latency: an owner `req` drop sampled at edge N changes `gnt` after edge N.
- `d` to `out`: zero cycles, combinational through the mux.
- Request changes: a requester may change `req` at any time. Non-owner requests are only examined at release or IDLE edges.
- Reset mid-grant: `reset` dominates every other condition at the edge. All registers return to reset values regardless of `req`.
- `gnt` is never multi-hot. `sel` always matches `gnt` when `busy`=1.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined: timeout expiry is active; no grant lasts more than `MAX_HOLD` consecutive cycles while others request.
- Undefined: the grant is held until the owner drops `req`, and `MAX_HOLD` has no effect. The counter may still be present but never causes release.

## Structure
- Shared include `arb_defs.vh`: `N_REQ`=4, state encodings `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1, and the reset value of `last`.
- Sub-module: one instance of the existing `mux4a1` for the data path.
- The FSM, pointer, counter and arbitration scan stay in `arbitro_rr4`.

## Test plan
- Reset, then `req`=4'b0000 -> `gnt`=0, `busy`=0, `out`=0. Assert `reset` during a grant -> all outputs zero at the next edge.
- `req`=4'b1111 held, each owner drops after 1 cycle -> grants cycle 0001, 0010, 0100, 1000, 0001 back-to-back, with no idle cycle.
- Only `req[2]`=1 with `d`=4'b0100 -> `gnt`=0100 after one edge, `sel`=2, `out`=1. Toggle `d[2]` -> `out` follows in the same cycle.
- With `ARB_TIMEOUT_EN` and `MAX_HOLD`=4, `req`=4'b0011 held -> `gnt` alternates 0001/0010, each lasting exactly 4 cycles.
- Without the macro, the same stimulus -> `gnt`=0001 for 20+ cycles until `req[0]` drops, then 0010 on the next edge.
- Owner drops `req` with no other requests -> `busy`=0 after one edge. A new `req[3]` then wins after one further edge, `sel`=3.

Source files
------------

// File: rtl/arbitro_rr4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: requester count,
// FSM encoding, pointer reset value and the rotating-priority scan.
package arbitro_rr4_pkg;

    localparam int N_REQ = 4;
    localparam logic [1:0] LAST_RST = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Returns {found, index}; the scan starts one past last and wraps back to last.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                           input logic [1:0]       last_v);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last_v + 2'(k);
            if (req_v[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4a1.sv
// Shared 4-input, 1-bit multiplexer placed on the arbitrated data path.
module mux4a1 (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic       d_i,
    input  logic [1:0] sel_i,
    output logic       out_o
);

    always_comb begin
        case (sel_i)
            2'd0:    out_o = a_i;
            2'd1:    out_o = b_i;
            2'd2:    out_o = c_i;
            default: out_o = d_i;
        endcase
    end

endmodule

// File: rtl/arbitro_rr4.sv
// Round-robin owner of mux4a1: registered one-hot grant and select, back-to-back handoff.
// Build option: define ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive cycles.
module arbitro_rr4
    import arbitro_rr4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] d,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             out
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (2**HOLD_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("arbitro_rr4: MAX_HOLD must be 1..15 and fit in HOLD_W bits");
    end

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [2:0]        pick;
    logic              expire;
    logic              mux_y;

`ifdef ARB_TIMEOUT_EN
    assign expire = (cnt_q == HOLD_W'(MAX_HOLD - 1));
`else
    assign expire = 1'b0;
`endif

    assign pick = rr_pick(req, last_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    state_d = ST_GRANT;
                    gnt_d   = N_REQ'(1) << pick[1:0];
                    sel_d   = pick[1:0];
                    last_d  = pick[1:0];
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (req[sel_q] && !expire) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end else if (pick[2]) begin
                    // last equals the owner here, so a lone owner wraps back to itself
                    gnt_d  = N_REQ'(1) << pick[1:0];
                    sel_d  = pick[1:0];
                    last_d = pick[1:0];
                    cnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= 2'b00;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    mux4a1 u_mux (
        .a_i   (d[0]),
        .b_i   (d[1]),
        .c_i   (d[2]),
        .d_i   (d[3]),
        .sel_i (sel_q),
        .out_o (mux_y)
    );

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == ST_GRANT);
    assign out  = busy & mux_y;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Randomized bench for arbitro_rr4 against an owner/pointer/hold-count reference model.
module tb_arbitro_rr4;

    localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] d = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       out;

    arbitro_rr4 #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .out   (out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // owner = -1 means no grant; hold = cycles the current owner has held so far
    int m_owner, m_last, m_sel, m_hold;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_sel   = 0;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        bit release_now;
        int win;
        if (m_owner >= 0 && r[m_owner] && !(TO_EN && m_hold >= MAXH)) begin
            m_hold++;
        end else begin
            release_now = 1'b1;
            win = -1;
            for (int k = 1; k <= 4 && win < 0; k++)
                if (r[(m_last + k) % 4]) win = (m_last + k) % 4;
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
                m_sel   = win;
                m_hold  = 1;
            end else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end
    endtask

    function automatic int exp_gnt();
        return (m_owner < 0) ? 0 : (1 << m_owner);
    endfunction

    function automatic int exp_out();
        return (m_owner < 0) ? 0 : int'(d[m_sel]);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".gnt"},  int'(gnt),  exp_gnt());
        chk({tag, ".sel"},  int'(sel),  m_sel);
        chk({tag, ".busy"}, int'(busy), (m_owner >= 0) ? 1 : 0);
        chk({tag, ".out"},  int'(out),  exp_out());
        chk({tag, ".onehot"}, ($countones(gnt) <= 1) ? 1 : 0, 1);
    endtask

    task automatic tick(input string tag, input logic rst, input logic [3:0] r, input logic [3:0] dd);
        reset = rst;
        req   = r;
        d     = dd;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(r);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] r;
        model_reset();

        tick("reset", 1'b1, 4'b0000, 4'b0000);
        tick("idle", 1'b0, 4'b0000, 4'b1111);
        tick("idle2", 1'b0, 4'b0000, 4'b1111);

        tick("rot_start", 1'b0, 4'b1111, 4'b1010);
        for (int i = 0; i < 5; i++)
            tick("rot_drop", 1'b0, 4'b1111 & ~gnt, 4'b1010);

        tick("mid_reset", 1'b1, 4'b1111, 4'b1111);
        tick("after_rst", 1'b0, 4'b0000, 4'b0000);

        tick("only2", 1'b0, 4'b0100, 4'b0100);
        chk("only2.gnt_const", int'(gnt), 4);
        d = 4'b0000;
        #1 chk("d_follow_lo", int'(out), exp_out());
        d = 4'b0100;
        #1 chk("d_follow_hi", int'(out), exp_out());

        tick("drop_all", 1'b0, 4'b0000, 4'b0100);
        tick("new3", 1'b0, 4'b1000, 4'b1000);
        chk("new3.sel_const", int'(sel), 3);

        tick("to_rst", 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 24; i++)
            tick("hold0011", 1'b0, 4'b0011, 4'($urandom));
        tick("drop0", 1'b0, 4'b0010, 4'b0010);

        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            tick("rand", ($urandom_range(0, 59) == 0), r, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
